// File: rtl/icache_assoc.sv
// Set-associative, read-only instruction cache with LRU ages, multi-word block fill,
// one-shot flush and hit/miss event counters.
module icache_assoc #(
  parameter int SETS     = 8,
  parameter int WAYS     = 2,
  parameter int BLKWORDS = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        iflush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int WB      = $clog2(BLKWORDS);
  localparam int WBW     = (WB == 0) ? 1 : WB;
  localparam int IB      = $clog2(SETS);
  localparam int AW      = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int IDX_LSB = 2 + WB;
  localparam int TAG_LSB = IDX_LSB + IB;
  localparam int TW      = 32 - TAG_LSB;

  typedef enum logic {IDLE, FILL} state_t;
  state_t state_reg, state_next;

  logic          valid_reg [SETS][WAYS];
  logic [AW-1:0] age_reg   [SETS][WAYS];
  logic [TW-1:0] tag_mem   [SETS][WAYS];
  logic [31:0]   data_mem  [SETS][WAYS][BLKWORDS];

  logic [TW-1:0]  fill_tag_reg;
  logic [IB-1:0]  fill_idx_reg;
  logic [AW-1:0]  fill_way_reg;
  logic [WBW-1:0] wcnt_reg;
  logic [31:0]    hit_cnt_reg, miss_cnt_reg;

  logic [TW-1:0]  req_tag;
  logic [IB-1:0]  req_idx;
  logic [WBW-1:0] req_woff;
  assign req_tag  = imemaddr[31:TAG_LSB];
  assign req_idx  = imemaddr[TAG_LSB-1:IDX_LSB];
  assign req_woff = WBW'((imemaddr >> 2) & 32'(BLKWORDS - 1));

  logic [WAYS-1:0] way_match;
  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_match
      assign way_match[gi] = valid_reg[req_idx][gi] && (tag_mem[req_idx][gi] == req_tag);
    end
  endgenerate

  // Victim: oldest way unless an invalid way exists; lowest invalid way wins.
  logic [AW-1:0] hit_way, victim_way;
  always_comb begin
    hit_way    = '0;
    victim_way = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (way_match[w]) hit_way = AW'(w);
    for (int w = WAYS - 1; w >= 0; w--)
      if (age_reg[req_idx][w] == AW'(WAYS - 1)) victim_way = AW'(w);
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_reg[req_idx][w]) victim_way = AW'(w);
  end

  logic idle, lookup, lookup_hit, miss_start, fill_accept, last_word, fill_done;
  assign idle        = (state_reg == IDLE);
  assign lookup      = idle && imemREN && !iflush;
  assign lookup_hit  = lookup && (|way_match);
  assign miss_start  = lookup && !(|way_match);
  assign fill_accept = (state_reg == FILL) && !iwait;
  assign last_word   = (wcnt_reg == WBW'(BLKWORDS - 1));
  assign fill_done   = fill_accept && last_word;

  // A hit in IDLE and a completed fill both count as an access for the ages.
  logic          touch_en;
  logic [IB-1:0] touch_idx;
  logic [AW-1:0] touch_way;
  assign touch_en  = lookup_hit || fill_done;
  assign touch_idx = idle ? req_idx : fill_idx_reg;
  assign touch_way = idle ? hit_way : fill_way_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (miss_start) state_next = FILL;
      FILL:    if (fill_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ihit     = 1'b0;
    imemload = '0;
    iREN     = 1'b0;
    iaddr    = '0;
    if (!RST) begin
      if (lookup_hit) begin
        ihit     = 1'b1;
        imemload = data_mem[req_idx][hit_way][req_woff];
      end
      if (state_reg == FILL) begin
        iREN  = 1'b1;
        iaddr = (32'(fill_tag_reg) << TAG_LSB) | (32'(fill_idx_reg) << IDX_LSB)
              | (32'(wcnt_reg) << 2);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= IDLE;
      wcnt_reg     <= '0;
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
      fill_tag_reg <= '0;
      fill_idx_reg <= '0;
      fill_way_reg <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          valid_reg[s][w] <= 1'b0;
          age_reg[s][w]   <= AW'(w);
        end
    end else begin
      state_reg <= state_next;
      if (idle && iflush)
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++)
            valid_reg[s][w] <= 1'b0;
      if (lookup_hit) hit_cnt_reg <= hit_cnt_reg + 32'd1;
      if (miss_start) begin
        fill_tag_reg <= req_tag;
        fill_idx_reg <= req_idx;
        fill_way_reg <= victim_way;
        wcnt_reg     <= '0;
        miss_cnt_reg <= miss_cnt_reg + 32'd1;
      end
      if (fill_accept) begin
        wcnt_reg <= last_word ? '0 : wcnt_reg + WBW'(1);
        if (last_word) valid_reg[fill_idx_reg][fill_way_reg] <= 1'b1;
      end
      if (touch_en) begin
        for (int w = 0; w < WAYS; w++)
          if (age_reg[touch_idx][w] < age_reg[touch_idx][touch_way])
            age_reg[touch_idx][w] <= age_reg[touch_idx][w] + AW'(1);
        age_reg[touch_idx][touch_way] <= '0;
      end
    end
  end

  // Tag and data storage carry no reset; the valid bits qualify them.
  always_ff @(posedge CLK) begin
    if (!RST && fill_accept) begin
      data_mem[fill_idx_reg][fill_way_reg][wcnt_reg] <= iload;
      if (last_word) tag_mem[fill_idx_reg][fill_way_reg] <= fill_tag_reg;
    end
  end

  assign hit_count  = hit_cnt_reg;
  assign miss_count = miss_cnt_reg;
endmodule
